morse_key_decoder: RTL and testbench

MORSE_KEY_DECODER -- requirements
Module: morse_key_decoder

---
 rtl/morse_key_decoder_pkg.sv | 78 +++++++
 rtl/morse_key_decoder_lut.sv | 27 ++
 rtl/morse_key_decoder.sv | 156 +++++++++++++++
 tb/tb_morse_key_decoder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_key_decoder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : morse_key_decoder_pkg
// Purpose  : Shared FSM encoding, timing multipliers and Morse-to-PS/2 table.
// Revision : 1.0
// ============================================================================
package morse_key_decoder_pkg;

    typedef logic [1:0] morse_state_t;

    localparam morse_state_t c_ST_IDLE = 2'd0;
    localparam morse_state_t c_ST_MARK = 2'd1;
    localparam morse_state_t c_ST_GAP  = 2'd2;
    localparam morse_state_t c_ST_WORD = 2'd3;

    localparam int         c_LETTER_MULT = 2;
    localparam int         c_WORD_MULT   = 5;
    localparam int         c_SAT_MULT    = 6;
    localparam logic [7:0] c_SPACE_CODE  = 8'h29;
    localparam logic [2:0] c_MAX_LEN     = 3'd5;

    typedef struct packed {
        logic       valid;
        logic [7:0] code;
    } lut_entry_t;

    // Symbols enter at the LSB, so the first symbol sent is the highest used
    // bit of pat; dot = 0, dash = 1. Unused upper pat bits are always zero.
    function automatic lut_entry_t morse_lookup(input logic [2:0] len,
                                                input logic [4:0] pat);
        lut_entry_t e;
        e.valid = 1'b1;
        e.code  = 8'h00;
        case ({len, pat})
            {3'd1, 5'b00000}: e.code = 8'h24; // E
            {3'd1, 5'b00001}: e.code = 8'h2C; // T
            {3'd2, 5'b00000}: e.code = 8'h43; // I
            {3'd2, 5'b00001}: e.code = 8'h1C; // A
            {3'd2, 5'b00010}: e.code = 8'h31; // N
            {3'd2, 5'b00011}: e.code = 8'h3A; // M
            {3'd3, 5'b00000}: e.code = 8'h1B; // S
            {3'd3, 5'b00001}: e.code = 8'h3C; // U
            {3'd3, 5'b00010}: e.code = 8'h2D; // R
            {3'd3, 5'b00011}: e.code = 8'h1D; // W
            {3'd3, 5'b00100}: e.code = 8'h23; // D
            {3'd3, 5'b00101}: e.code = 8'h42; // K
            {3'd3, 5'b00110}: e.code = 8'h34; // G
            {3'd3, 5'b00111}: e.code = 8'h44; // O
            {3'd4, 5'b00000}: e.code = 8'h33; // H
            {3'd4, 5'b00001}: e.code = 8'h2A; // V
            {3'd4, 5'b00010}: e.code = 8'h2B; // F
            {3'd4, 5'b00100}: e.code = 8'h4B; // L
            {3'd4, 5'b00110}: e.code = 8'h4D; // P
            {3'd4, 5'b00111}: e.code = 8'h3B; // J
            {3'd4, 5'b01000}: e.code = 8'h32; // B
            {3'd4, 5'b01001}: e.code = 8'h22; // X
            {3'd4, 5'b01010}: e.code = 8'h21; // C
            {3'd4, 5'b01011}: e.code = 8'h35; // Y
            {3'd4, 5'b01100}: e.code = 8'h1A; // Z
            {3'd4, 5'b01101}: e.code = 8'h15; // Q
            {3'd5, 5'b00000}: e.code = 8'h2E; // 5
            {3'd5, 5'b00001}: e.code = 8'h25; // 4
            {3'd5, 5'b00011}: e.code = 8'h26; // 3
            {3'd5, 5'b00111}: e.code = 8'h1E; // 2
            {3'd5, 5'b01111}: e.code = 8'h16; // 1
            {3'd5, 5'b10000}: e.code = 8'h36; // 6
            {3'd5, 5'b11000}: e.code = 8'h3D; // 7
            {3'd5, 5'b11100}: e.code = 8'h3E; // 8
            {3'd5, 5'b11110}: e.code = 8'h46; // 9
            {3'd5, 5'b11111}: e.code = 8'h45; // 0
            default:          e.valid = 1'b0;
        endcase
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/morse_key_decoder_lut.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : morse_lut
// Purpose  : Combinational {len,pat} to PS/2 set-2 make code lookup.
// Revision : 1.0
// ============================================================================
module morse_lut
    import morse_key_decoder_pkg::*;
(
    input  logic [2:0] i_len,
    input  logic [4:0] i_pat,
    output logic [7:0] o_code,
    output logic       o_valid
);

    lut_entry_t w_entry;

    always_comb begin
        w_entry = morse_lookup(i_len, i_pat);
    end

    assign o_code  = w_entry.code;
    assign o_valid = w_entry.valid;

endmodule
`default_nettype wire

// File: rtl/morse_key_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : morse_key_decoder
// Purpose  : Straight-key Morse decoder emitting PS/2 set-2 make codes.
// Revision : 1.0
// ============================================================================
module morse_key_decoder
    import morse_key_decoder_pkg::*;
#(
    parameter logic [23:0] UNIT_CYCLES = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       morse_in,
    output logic [7:0] scan_code,
    output logic       scan_code_strb,
    output logic       err_strb
);

    localparam int c_UNIT    = int'(UNIT_CYCLES);
    localparam int c_CNT_MAX = c_SAT_MULT * c_UNIT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    // r_cnt is cleared at the end of an edge cycle, so it lags elapsed time:
    // at a fall it holds (mark length - 1); in the k-th low cycle it holds k-2.
    localparam logic [c_CNT_W-1:0] c_CNT_SAT    = c_CNT_W'(c_CNT_MAX);
    localparam logic [c_CNT_W-1:0] c_DASH_MIN   = c_CNT_W'(c_LETTER_MULT * c_UNIT - 1);
    localparam logic [c_CNT_W-1:0] c_LETTER_HIT = c_CNT_W'(c_LETTER_MULT * c_UNIT - 2);
    localparam logic [c_CNT_W-1:0] c_WORD_HIT   = c_CNT_W'(c_WORD_MULT * c_UNIT - 2);

    logic               r_sync1;
    logic               r_key_s;
    logic               r_key_d;
    logic [c_CNT_W-1:0] r_cnt;
    morse_state_t       r_state;
    morse_state_t       w_state_next;
    logic [2:0]         r_len;
    logic [4:0]         r_pat;
    logic               r_ovf;

    logic               w_rise;
    logic               w_fall;
    logic               w_symbol;
    logic               w_letter_hit;
    logic               w_word_hit;
    logic               w_mark_done;
    logic [7:0]         w_lut_code;
    logic               w_lut_valid;

    assign w_rise       = r_key_s & ~r_key_d;
    assign w_fall       = ~r_key_s & r_key_d;
    assign w_symbol     = (r_cnt >= c_DASH_MIN);
    assign w_mark_done  = (r_state == c_ST_MARK) && w_fall;
    // A rise in the same cycle as a threshold suppresses decode and space.
    assign w_letter_hit = (r_state == c_ST_GAP)  && !w_rise && (r_cnt == c_LETTER_HIT);
    assign w_word_hit   = (r_state == c_ST_WORD) && !w_rise && (r_cnt == c_WORD_HIT);

    morse_lut u_lut (
        .i_len   (r_len),
        .i_pat   (r_pat),
        .o_code  (w_lut_code),
        .o_valid (w_lut_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_key_s <= 1'b0;
            r_key_d <= 1'b0;
        end else begin
            r_sync1 <= morse_in;
            r_key_s <= r_sync1;
            r_key_d <= r_key_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_rise || w_fall) begin
            r_cnt <= '0;
        end else if (r_cnt != c_CNT_SAT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_rise) w_state_next = c_ST_MARK;
            c_ST_MARK: if (w_fall) w_state_next = c_ST_GAP;
            c_ST_GAP: begin
                if (w_rise)            w_state_next = c_ST_MARK;
                else if (w_letter_hit) w_state_next = c_ST_WORD;
            end
            c_ST_WORD: begin
                if (w_rise)          w_state_next = c_ST_MARK;
                else if (w_word_hit) w_state_next = c_ST_IDLE;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Symbol group: once overflowed, it stays frozen until the next decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len <= 3'd0;
            r_pat <= 5'd0;
            r_ovf <= 1'b0;
        end else if (w_letter_hit) begin
            r_len <= 3'd0;
            r_pat <= 5'd0;
            r_ovf <= 1'b0;
        end else if (w_mark_done && !r_ovf) begin
            if (r_len == c_MAX_LEN) begin
                r_ovf <= 1'b1;
            end else begin
                r_pat <= {r_pat[3:0], w_symbol};
                r_len <= r_len + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_code      <= 8'h00;
            scan_code_strb <= 1'b0;
            err_strb       <= 1'b0;
        end else begin
            scan_code_strb <= 1'b0;
            err_strb       <= 1'b0;
            if (w_letter_hit) begin
                if (!r_ovf && w_lut_valid) begin
                    scan_code      <= w_lut_code;
                    scan_code_strb <= 1'b1;
                end else begin
                    err_strb <= 1'b1;
                end
            end else if (w_word_hit) begin
                scan_code      <= c_SPACE_CODE;
                scan_code_strb <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_morse_key_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_morse_key_decoder
// Purpose  : Self-checking bench with a segment-level Morse reference model.
// Revision : 1.0
// ============================================================================
module tb_morse_key_decoder;

    localparam int U = 10;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       morse_in = 1'b0;
    logic [7:0] scan_code;
    logic       scan_code_strb;
    logic       err_strb;

    always #5 clk = ~clk;

    morse_key_decoder #(.UNIT_CYCLES(24'd10)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .morse_in       (morse_in),
        .scan_code      (scan_code),
        .scan_code_strb (scan_code_strb),
        .err_strb       (err_strb)
    );

    typedef struct { bit lvl; int len; } seg_t;
    typedef struct { int cyc; bit err; logic [7:0] code; } evt_t;

    seg_t segs[$];
    evt_t obs[$];
    evt_t exp_q[$];
    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   overlap     = 0;
    logic [7:0] exp_last_code = 8'h00;

    string morse_tab [0:35] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
        "---..", "----."};
    logic [7:0] code_tab [0:35] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        evt_t e;
        if (scan_code_strb) begin
            e.cyc = cyc; e.err = 1'b0; e.code = scan_code;
            obs.push_back(e);
        end
        if (err_strb) begin
            e.cyc = cyc; e.err = 1'b1; e.code = 8'h00;
            obs.push_back(e);
        end
        if (scan_code_strb && err_strb) overlap++;
    end

    // Consecutive segments of equal level merge, so the list always alternates.
    task automatic add_seg(input bit lvl, input int len);
        seg_t s;
        if (segs.size() > 0 && segs[$].lvl == lvl) begin
            segs[$].len += len;
        end else begin
            s.lvl = lvl; s.len = len;
            segs.push_back(s);
        end
    endtask

    task automatic add_letter(input string pattern, input int dot, input int dash,
                              input int intra, input int tail);
        for (int i = 0; i < pattern.len(); i++) begin
            add_seg(1'b1, (pattern[i] == "-") ? dash : dot);
            add_seg(1'b0, (i == pattern.len() - 1) ? tail : intra);
        end
    endtask

    function automatic evt_t decode_evt(input string g, input int c);
        evt_t e;
        e.cyc = c; e.err = 1'b1; e.code = 8'h00;
        for (int k = 0; k < 36; k++) begin
            if (g.len() <= 5 && morse_tab[k] == g) begin
                e.err = 1'b0; e.code = code_tab[k];
            end
        end
        return e;
    endfunction

    // Key-level reference: a gap of >= 2U cycles ends a letter, >= 5U adds a
    // space; results appear 2 (synchronizer) + threshold cycles after gap start.
    function automatic void model(input int t0);
        string grp = "";
        string sym;
        int    s = t0;
        evt_t  e;
        foreach (segs[i]) begin
            if (segs[i].lvl) begin
                sym = (segs[i].len >= 2*U) ? "-" : ".";
                grp = {grp, sym};
            end else if (grp.len() > 0 && segs[i].len >= 2*U) begin
                e = decode_evt(grp, s + 2 + 2*U);
                exp_q.push_back(e);
                if (!e.err) exp_last_code = e.code;
                grp = "";
                if (segs[i].len >= 5*U) begin
                    e.cyc = s + 2 + 5*U; e.err = 1'b0; e.code = 8'h29;
                    exp_q.push_back(e);
                    exp_last_code = 8'h29;
                end
            end
            s += segs[i].len;
        end
    endfunction

    task automatic run_segs();
        @(negedge clk);
        obs.delete();
        exp_q.delete();
        model(cyc);
        foreach (segs[i]) begin
            morse_in = segs[i].lvl;
            repeat (segs[i].len) @(negedge clk);
        end
        morse_in = 1'b0;
        segs.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        morse_in = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (scan_code !== 8'h00) begin
            miscompares++; $display("FAIL reset_code: got %02h expected 00", scan_code);
        end
        vectors++;
        if (scan_code_strb !== 1'b0 || err_strb !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_strobes: got strb=%0b err=%0b expected 0 0", scan_code_strb, err_strb);
        end
        rst_n = 1'b1;
        obs.delete();
        repeat (120) @(negedge clk);
        vectors++;
        if (obs.size() != 0) begin
            miscompares++; $display("FAIL reset_idle: got %0d strobes expected 0", obs.size());
        end
    endtask

    task automatic test_letters();
        add_letter(".", 10, 30, 10, 30);
        add_letter("...", 10, 30, 10, 30);
        add_letter("---", 10, 30, 10, 70);
        run_segs();
        vectors++;
        if (obs.size() != exp_q.size()) begin
            miscompares++; $display("FAIL letters_count: got %0d expected %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i].cyc != exp_q[i].cyc || obs[i].err !== exp_q[i].err ||
                (!exp_q[i].err && obs[i].code !== exp_q[i].code)) begin
                miscompares++;
                $display("FAIL letters_evt%0d: got cyc=%0d err=%0b code=%02h expected cyc=%0d err=%0b code=%02h",
                         i, obs[i].cyc, obs[i].err, obs[i].code, exp_q[i].cyc, exp_q[i].err, exp_q[i].code);
            end
        end
        vectors++;
        if (scan_code !== exp_last_code) begin
            miscompares++; $display("FAIL letters_hold: got %02h expected %02h", scan_code, exp_last_code);
        end
    endtask

    task automatic test_word_space();
        add_letter(".", 10, 30, 10, 200);
        run_segs();
        vectors++;
        if (obs.size() != 2 || exp_q.size() != 2) begin
            miscompares++; $display("FAIL word_count: got %0d strobes expected 2", obs.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i].cyc != exp_q[i].cyc || obs[i].err !== exp_q[i].err || obs[i].code !== exp_q[i].code) begin
                miscompares++;
                $display("FAIL word_evt%0d: got cyc=%0d code=%02h expected cyc=%0d code=%02h",
                         i, obs[i].cyc, obs[i].code, exp_q[i].cyc, exp_q[i].code);
            end
        end
    endtask

    task automatic test_overflow();
        add_letter("......", 10, 30, 10, 30);
        add_letter("-", 10, 30, 10, 70);
        run_segs();
        vectors++;
        if (obs.size() != exp_q.size()) begin
            miscompares++; $display("FAIL ovf_count: got %0d expected %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i].cyc != exp_q[i].cyc || obs[i].err !== exp_q[i].err ||
                (!exp_q[i].err && obs[i].code !== exp_q[i].code)) begin
                miscompares++;
                $display("FAIL ovf_evt%0d: got cyc=%0d err=%0b code=%02h expected cyc=%0d err=%0b code=%02h",
                         i, obs[i].cyc, obs[i].err, obs[i].code, exp_q[i].cyc, exp_q[i].err, exp_q[i].code);
            end
        end
        vectors++;
        if (overlap != 0) begin
            miscompares++; $display("FAIL ovf_overlap: got %0d overlapping strobes expected 0", overlap);
        end
    endtask

    task automatic test_reset_mid_mark();
        @(negedge clk);
        obs.delete();
        morse_in = 1'b1; repeat (10) @(negedge clk);
        morse_in = 1'b0; repeat (10) @(negedge clk);
        morse_in = 1'b1; repeat (12) @(negedge clk);
        rst_n = 1'b0;
        morse_in = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (scan_code !== 8'h00 || scan_code_strb !== 1'b0 || err_strb !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got code=%02h strb=%0b err=%0b expected 00 0 0",
                     scan_code, scan_code_strb, err_strb);
        end
        rst_n = 1'b1;
        exp_last_code = 8'h00;
        repeat (40) @(negedge clk);
        vectors++;
        if (obs.size() != 0) begin
            miscompares++; $display("FAIL midreset_partial: got %0d strobes expected 0", obs.size());
        end
        add_letter("-", 10, 30, 10, 70);
        run_segs();
        vectors++;
        if (obs.size() < 1 || obs[0].err !== 1'b0 || obs[0].code !== 8'h2C || obs[0].cyc != exp_q[0].cyc) begin
            miscompares++;
            $display("FAIL midreset_T: got %0d strobes first code=%02h expected code=2C at cyc=%0d",
                     obs.size(), (obs.size() > 0) ? obs[0].code : 8'hxx, exp_q[0].cyc);
        end
    endtask

    task automatic test_thresholds();
        add_seg(1'b1, 19); add_seg(1'b0, 30);
        add_seg(1'b1, 20); add_seg(1'b0, 30);
        add_seg(1'b1, 10); add_seg(1'b0, 19); add_seg(1'b1, 10); add_seg(1'b0, 30);
        add_seg(1'b1, 10); add_seg(1'b0, 20); add_seg(1'b1, 10); add_seg(1'b0, 70);
        run_segs();
        vectors++;
        if (obs.size() != exp_q.size()) begin
            miscompares++; $display("FAIL thresh_count: got %0d expected %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i].cyc != exp_q[i].cyc || obs[i].err !== exp_q[i].err ||
                (!exp_q[i].err && obs[i].code !== exp_q[i].code)) begin
                miscompares++;
                $display("FAIL thresh_evt%0d: got cyc=%0d err=%0b code=%02h expected cyc=%0d err=%0b code=%02h",
                         i, obs[i].cyc, obs[i].err, obs[i].code, exp_q[i].cyc, exp_q[i].err, exp_q[i].code);
            end
        end
    endtask

    task automatic test_random();
        int nsym;
        for (int l = 0; l < 25; l++) begin
            nsym = $urandom_range(6, 1);
            for (int s = 0; s < nsym; s++) begin
                add_seg(1'b1, ($urandom_range(1, 0) == 1) ? $urandom_range(70, 20) : $urandom_range(19, 3));
                if (s != nsym - 1) add_seg(1'b0, $urandom_range(19, 3));
            end
            if (l == 24)                         add_seg(1'b0, 80);
            else if ($urandom_range(3, 0) == 0)  add_seg(1'b0, $urandom_range(80, 50));
            else                                 add_seg(1'b0, $urandom_range(49, 20));
        end
        run_segs();
        vectors++;
        if (obs.size() != exp_q.size()) begin
            miscompares++; $display("FAIL random_count: got %0d expected %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i].cyc != exp_q[i].cyc || obs[i].err !== exp_q[i].err ||
                (!exp_q[i].err && obs[i].code !== exp_q[i].code)) begin
                miscompares++;
                $display("FAIL random_evt%0d: got cyc=%0d err=%0b code=%02h expected cyc=%0d err=%0b code=%02h",
                         i, obs[i].cyc, obs[i].err, obs[i].code, exp_q[i].cyc, exp_q[i].err, exp_q[i].code);
            end
        end
        vectors++;
        if (scan_code !== exp_last_code || overlap != 0) begin
            miscompares++;
            $display("FAIL random_hold: got code=%02h overlap=%0d expected code=%02h overlap=0",
                     scan_code, overlap, exp_last_code);
        end
    endtask

    initial begin
        test_reset();
        test_letters();
        test_word_space();
        test_overflow();
        test_thresholds();
        test_reset_mid_mark();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
